hash_msg_padder: RTL and testbench
==================================

# hash_msg_padder

Upstream feeder for the 128-bit hash stage. Accepts a message as a byte stream with valid/ready handshake and packs it big-endian into 128-bit blocks. It applies length padding: a 0x80 marker, zero fill, then the 32-bit message bit-length in the final four bytes of the last block. Blocks are presented on a valid/ready output whose data maps directly onto the hash stage's 128-bit `data_in`.

## Interface
- `PAD_BYTE`, default 8'h80: marker byte appended after the last message byte.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_data`  in  8: message byte.
- `in_valid`  in  1: `in_data`/`in_last` valid.
- `in_last`  in  1: current byte is the final byte of the message. Every message is at least 1 byte.
- `in_ready`  out  1: byte accepted when `in_valid && in_ready`.
- `blk_data`  out  128: packed block. First byte of the block is in [127:120].
- `blk_valid`  out  1: block available.
- `blk_last`  out  1: block is the final, length-carrying block of the message.
- `blk_ready`  in  1: block consumed when `blk_valid && blk_ready`.

## Operation
- Internal registers:
  - 128-bit buffer.
  - 4-bit write index `idx` (bytes in buffer).
  - 29-bit byte counter `cnt`; wraps mod 2^29, so the bit length is `{cnt,3'b000}` mod 2^32.
  - `pad_pending` flag.
- States:
  - **FILL**
    - `in_ready=1`, `blk_valid=0`.
    - On accept: write the byte at lane `idx`, then `idx++` and `cnt++`.
    - If `in_last` and the buffer is now full (16 bytes): set `pad_pending` and go to EMIT_FULL.
    - Else if `in_last`: go to PAD.
    - Else if the buffer is now full: go to EMIT_FULL.
  - **EMIT_FULL**
    - `blk_valid=1`, `blk_last=0`.
    - On handshake: clear the buffer and set `idx=0`.
    - Go to PAD if `pad_pending` (and clear it), else go to FILL.
  - **PAD**, one cycle, no handshakes:
    - Write `PAD_BYTE` at lane `idx` and zero lanes `idx+1`..15.
    - If `idx<=11`: write the bit length big-endian into lanes 12..15 and go to EMIT_FINAL.
    - Else: go to EMIT_PAD.
  - **EMIT_PAD**
    - `blk_valid=1`, `blk_last=0`.
    - On handshake: load the buffer with 12 zero bytes plus the bit length, then go to EMIT_FINAL.
  - **EMIT_FINAL**
    - `blk_valid=1`, `blk_last=1`.
    - On handshake: clear the buffer, `idx`, and `cnt`, then go to FILL.
- `in_ready` is 0 in every state except FILL, and is 0 whenever `rst=1`.
- `blk_data` and `blk_last` are held stable while `blk_valid && !blk_ready`.
- Bytes are never dropped or duplicated under any back-pressure pattern.

## Timing
- Reset values:
  - State FILL; `blk_valid=0`, `blk_last=0`, `blk_data=0`.
  - `idx=0`, `cnt=0`, `pad_pending=0`; `in_ready=0` during the reset cycle.
- `blk_valid` rises the cycle after the 16th byte of a block is accepted.
- Full-rate throughput: 17 cycles per non-final block with `blk_ready` held high.
- Latency from last-byte accept:
  - Short final block (`idx<=11`): `blk_valid` with `blk_last` rises 2 cycles after the accept (via PAD).
  - `idx` in 12..15: non-last block at +2, final block the cycle after its handshake.
  - Exact multiple of 16: full data block at +1, then PAD, then pad block with length.
- Reset mid-operation discards the partial buffer, the count, and any pending block. `blk_valid` falls in the cycle after `rst` is sampled.
- `blk_ready` asserted without `blk_valid` has no effect.

## Structure
- Shared package `hash_pkg` holds:
  - State enum (FILL, EMIT_FULL, PAD, EMIT_PAD, EMIT_FINAL).
  - `BLK_W=128` and `LEN_W=32`.
  - `PAD_BYTE` default value.
- Single module; no sub-module. Byte-lane write logic is an indexed loop inside the module.

## Test plan
- Single byte 0x61 with `in_last` -> one block `61800000_00000000_00000000_00000008`, `blk_last=1`.
- Bytes 0x00..0x0F, `in_last` on 0x0F -> `00010203_..._0C0D0E0F` with `blk_last=0`, then `80000000_00000000_00000000_00000080` with `blk_last=1`.
- Twelve bytes 0xAA -> `AAAAAAAA×3` with lanes 12..15 = `80000000`, `blk_last=0`; then zeros with length `00000060`, `blk_last=1`.
- Eleven bytes 0xAA -> single block `AA×11, 80, 00000058`, `blk_last=1`.
- Back-pressure: hold `blk_ready=0` for 5 cycles while `blk_valid=1` -> `blk_data` and `blk_last` unchanged, `in_ready=0`, no input bytes consumed; the full sequence from scenario 2 still matches.
- Reset mid-message: accept 7 bytes, pulse `rst` for 1 cycle, then send 0x61 with `in_last` -> output identical to scenario 1.

Source files
------------

// File: rtl/hash_pkg.sv
// Shared definitions for the 128-bit hash front end: block/length widths,
// the default padding marker and the message padder state encoding.
package hash_pkg;

  localparam int BLK_W = 128;
  localparam int LEN_W = 32;

  localparam logic [7:0] PAD_BYTE_DEFAULT = 8'h80;

  typedef enum logic [2:0] {
    S_FILL       = 3'd0,
    S_EMIT_FULL  = 3'd1,
    S_PAD        = 3'd2,
    S_EMIT_PAD   = 3'd3,
    S_EMIT_FINAL = 3'd4
  } state_t;

endpackage

// File: rtl/hash_msg_padder.sv
// Packs a byte stream big-endian into 128-bit blocks and appends the marker
// byte, zero fill and 32-bit message bit length in the last block.
module hash_msg_padder
  import hash_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [BLK_W-1:0] blk_data,
  output logic             blk_valid,
  output logic             blk_last,
  input  logic             blk_ready,
  output logic [2:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; a producer holds its payload stable while valid && !ready.

  state_t           r_state;
  logic [BLK_W-1:0] r_buf;
  logic [3:0]       r_idx;
  logic [28:0]      r_cnt;
  logic             r_pad_pending;

  logic             w_accept;
  logic             w_full;
  logic [LEN_W-1:0] w_len;
  logic [BLK_W-1:0] w_fill_buf;
  logic [BLK_W-1:0] w_pad_buf;

  assign w_accept = in_valid && in_ready;
  assign w_full   = (r_idx == 4'd15);
  assign w_len    = {r_cnt, 3'b000};

  // Lane i occupies bits [127-8i -: 8], so byte 0 lands in the top lane.
  always_comb begin
    w_fill_buf = r_buf;
    w_pad_buf  = r_buf;
    for (int i = 0; i < 16; i++) begin
      if (4'(i) == r_idx) begin
        w_fill_buf[BLK_W-1-8*i -: 8] = in_data;
        w_pad_buf[BLK_W-1-8*i -: 8]  = PAD_BYTE;
      end else if (4'(i) > r_idx) begin
        w_pad_buf[BLK_W-1-8*i -: 8]  = 8'h00;
      end
    end
    if (r_idx <= 4'd11) begin
      w_pad_buf[LEN_W-1:0] = w_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_FILL;
      r_buf         <= '0;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_pad_pending <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            r_buf <= w_fill_buf;
            r_idx <= r_idx + 4'd1;
            r_cnt <= r_cnt + 29'd1;
            if (in_last && w_full) begin
              r_pad_pending <= 1'b1;
              r_state       <= S_EMIT_FULL;
            end else if (in_last) begin
              r_state <= S_PAD;
            end else if (w_full) begin
              r_state <= S_EMIT_FULL;
            end
          end
        end
        S_EMIT_FULL: begin
          if (blk_ready) begin
            r_buf <= '0;
            r_idx <= '0;
            if (r_pad_pending) begin
              r_pad_pending <= 1'b0;
              r_state       <= S_PAD;
            end else begin
              r_state <= S_FILL;
            end
          end
        end
        S_PAD: begin
          r_buf   <= w_pad_buf;
          r_state <= (r_idx <= 4'd11) ? S_EMIT_FINAL : S_EMIT_PAD;
        end
        S_EMIT_PAD: begin
          // Marker did not leave room for the length: it gets a block of its own.
          if (blk_ready) begin
            r_buf   <= {{(BLK_W-LEN_W){1'b0}}, w_len};
            r_state <= S_EMIT_FINAL;
          end
        end
        S_EMIT_FINAL: begin
          if (blk_ready) begin
            r_buf   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_state <= S_FILL;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign in_ready  = (r_state == S_FILL) && !rst;
  assign blk_valid = (r_state == S_EMIT_FULL) || (r_state == S_EMIT_PAD) ||
                     (r_state == S_EMIT_FINAL);
  assign blk_last  = (r_state == S_EMIT_FINAL);
  assign blk_data  = r_buf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_hash_msg_padder.sv
// Self-checking bench for hash_msg_padder: table of known messages, a
// back-pressure hold, reset mid-message and randomized messages checked by a scoreboard.
module tb_hash_msg_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [127:0] blk_data;
  logic         blk_valid;
  logic         blk_last;
  logic         blk_ready;
  logic [2:0]   dbg_state;

  hash_msg_padder dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_last  (blk_last),
    .blk_ready (blk_ready),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / ready driver ----------------
  always #5 clk = ~clk;

  int ready_mode = 0;  // 0: always ready, 1: random, 2: driven by the test
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) blk_ready = 1'b1;
    else if (ready_mode == 1) blk_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- scoreboard ----------------
  logic [128:0] exp_q[$];  // {last, data}
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [128:0] act, input logic [128:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {128'b0, act}, {128'b0, exp});
  endtask

  logic         prev_stall = 1'b0;
  logic [128:0] prev_blk;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk1("hold_valid", blk_valid, 1'b1);
        chk("hold_blk", {blk_last, blk_data}, prev_blk);
      end
      if (blk_valid) chk1("in_ready_while_emit", in_ready, 1'b0);
      if (blk_valid && blk_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_blk", {blk_last, blk_data}, 129'b0);
          if ({blk_last, blk_data} == 129'b0) chk1("unexpected_blk_zero", 1'b1, 1'b0);
        end else begin
          chk("blk", {blk_last, blk_data}, exp_q.pop_front());
        end
      end
      prev_stall = blk_valid && !blk_ready;
      prev_blk   = {blk_last, blk_data};
    end
  end

  // ---------------- reference model ----------------
  task automatic push_model(input logic [7:0] m[$]);
    logic [127:0] b;
    logic [31:0]  len;
    int lane;
    b    = '0;
    lane = 0;
    len  = 32'(m.size()) * 32'd8;
    for (int i = 0; i < m.size(); i++) begin
      b[127-8*lane -: 8] = m[i];
      lane++;
      if (lane == 16) begin
        exp_q.push_back({1'b0, b});
        b    = '0;
        lane = 0;
      end
    end
    b[127-8*lane -: 8] = 8'h80;
    if (lane <= 11) begin
      b[31:0] = len;
      exp_q.push_back({1'b1, b});
    end else begin
      exp_q.push_back({1'b0, b});
      exp_q.push_back({1'b1, 96'b0, len});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input logic l);
    int t;
    in_data  = b;
    in_last  = l;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk1("in_ready_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] m[$], input logic with_last, input int gap_max);
    for (int i = 0; i < m.size(); i++) begin
      send_byte(m[i], with_last && (i == m.size() - 1));
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_left", 129'(exp_q.size()), 129'(0));
    exp_q.delete();
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int           n;
    logic [7:0]   start;
    logic [7:0]   step;
    int           nblk;
    logic [128:0] e0;
    logic [128:0] e1;
  } vec_t;

  vec_t         tbl[4];
  logic [7:0]   m[$];
  logic [128:0] held;
  int           lens[3];

  initial begin
    tbl[0] = '{1,  8'h61, 8'h00, 1, {1'b1, 128'h61800000_00000000_00000000_00000008}, 129'b0};
    tbl[1] = '{16, 8'h00, 8'h01, 2, {1'b0, 128'h00010203_04050607_08090A0B_0C0D0E0F},
                                    {1'b1, 128'h80000000_00000000_00000000_00000080}};
    tbl[2] = '{12, 8'hAA, 8'h00, 2, {1'b0, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_80000000},
                                    {1'b1, 128'h00000000_00000000_00000000_00000060}};
    tbl[3] = '{11, 8'hAA, 8'h00, 1, {1'b1, 128'hAAAAAAAA_AAAAAAAA_AAAAAA80_00000058}, 129'b0};
    lens   = '{15, 32, 28};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; blk_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_blk_valid", blk_valid, 1'b0);
    chk1("rst_blk_last", blk_last, 1'b0);
    chk("rst_blk_data", {1'b0, blk_data}, 129'b0);
    chk("rst_state", 129'(dbg_state), 129'(0));
    rst = 1'b0;

    // Table-driven known messages, blk_ready held high.
    for (int v = 0; v < 4; v++) begin
      m.delete();
      for (int i = 0; i < tbl[v].n; i++) m.push_back(tbl[v].start + 8'(i) * tbl[v].step);
      exp_q.push_back(tbl[v].e0);
      if (tbl[v].nblk == 2) exp_q.push_back(tbl[v].e1);
      send_msg(m, 1'b1, 0);
      wait_drain();
    end

    // Back-pressure: hold the first block of the 16-byte message for 5 cycles.
    ready_mode = 2;
    blk_ready  = 1'b0;
    m.delete();
    for (int i = 0; i < 16; i++) m.push_back(8'(i));
    exp_q.push_back(tbl[1].e0);
    exp_q.push_back(tbl[1].e1);
    send_msg(m, 1'b1, 0);
    chk1("full_blk_latency", blk_valid, 1'b1);
    held = {blk_last, blk_data};
    in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_hold", {blk_last, blk_data}, held);
      chk1("bp_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    blk_ready = 1'b1;
    ready_mode = 0;
    wait_drain();

    // Reset mid-message discards the partial buffer and count.
    m.delete();
    for (int i = 0; i < 7; i++) m.push_back(8'h30 + 8'(i));
    send_msg(m, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk1("midrst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    exp_q.push_back(tbl[0].e0);
    send_byte(8'h61, 1'b1);
    chk1("short_lat_pad", blk_valid, 1'b0);
    @(posedge clk);
    #1;
    chk1("short_lat_valid", blk_valid, 1'b1);
    chk1("short_lat_last", blk_last, 1'b1);
    wait_drain();

    // Reset while a full block is pending drops that block.
    ready_mode = 2;
    blk_ready  = 1'b0;
    m.delete();
    for (int i = 0; i < 16; i++) m.push_back(8'h50);
    send_msg(m, 1'b0, 0);
    chk1("pend_valid", blk_valid, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk1("pend_rst_valid", blk_valid, 1'b0);
    rst = 1'b0;
    ready_mode = 0;
    exp_q.push_back(tbl[0].e0);
    send_byte(8'h61, 1'b1);
    wait_drain();

    // Randomized messages with random back-pressure and input gaps.
    ready_mode = 1;
    for (int k = 0; k < 8; k++) begin
      int n;
      n = (k < 3) ? lens[k] : int'($urandom_range(1, 40));
      m.delete();
      for (int i = 0; i < n; i++) m.push_back(8'($urandom_range(0, 255)));
      push_model(m);
      send_msg(m, 1'b1, 2);
      wait_drain();
    end

    ready_mode = 0;
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
